// File: rtl/decode_regfile_if.sv
// Decode-stage bundle: D fields, forwarding sources, writeback port, and the
// E pipeline register / architectural state driven back out.
interface decode_regfile_if;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic [1:0]  D_stat;
  logic        E_bubble;
  logic [3:0]  e_dstE;
  logic [63:0] e_valE;
  logic [3:0]  M_dstE, M_dstM;
  logic [63:0] M_valE, m_valM;
  logic [3:0]  W_dstE, W_dstM;
  logic [63:0] W_valE, W_valM;
  logic [1:0]  W_stat;
  logic [3:0]  d_srcA, d_srcB;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [63:0] E_valA, E_valB, E_valC;
  logic [1:0]  E_stat;
  logic [63:0] reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7;
  logic [63:0] reg8, reg9, reg10, reg11, reg12, reg13, reg14, reg15;

  modport master (
    output D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, D_stat, E_bubble,
           e_dstE, e_valE, M_dstE, M_dstM, M_valE, m_valM,
           W_dstE, W_dstM, W_valE, W_valM, W_stat,
    input  d_srcA, d_srcB, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB,
           E_valA, E_valB, E_valC, E_stat,
           reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7,
           reg8, reg9, reg10, reg11, reg12, reg13, reg14, reg15
  );
  modport slave (
    input  D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, D_stat, E_bubble,
           e_dstE, e_valE, M_dstE, M_dstM, M_valE, m_valM,
           W_dstE, W_dstM, W_valE, W_valM, W_stat,
    output d_srcA, d_srcB, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB,
           E_valA, E_valB, E_valC, E_stat,
           reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7,
           reg8, reg9, reg10, reg11, reg12, reg13, reg14, reg15
  );
endinterface

// File: rtl/decode_regfile.sv
// Y86-64 decode stage: 16x64 register file, source/dest selection,
// forwarding of valA/valB, and the E pipeline register.
module decode_regfile (
  input  logic             clk,
  input  logic             rst,
  decode_regfile_if.slave  bus
);
  localparam logic [1:0] STAT_AOK = 2'b00;
  localparam logic [3:0] RNONE    = 4'hF;

  typedef struct packed {
    logic [3:0]  icode, ifun, dstE, dstM, srcA, srcB;
    logic [63:0] valA, valB, valC;
    logic [1:0]  stat;
  } ereg_t;

  localparam ereg_t E_NOP = '{icode: 4'h1, ifun: 4'h0, dstE: RNONE, dstM: RNONE,
                              srcA: RNONE, srcB: RNONE, valA: 64'h0, valB: 64'h0,
                              valC: 64'h0, stat: STAT_AOK};

  logic [15:0][63:0] rf_q, rf_d;
  ereg_t             e_q, e_d;
  logic [3:0]        src_a, src_b, dst_e, dst_m;
  logic [63:0]       val_a, val_b;

  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (bus.D_icode)
      4'h2, 4'h4, 4'h6, 4'hA: src_a = bus.D_rA;
      4'h9, 4'hB:             src_a = 4'h4;
      default: ;
    endcase
    case (bus.D_icode)
      4'h4, 4'h5, 4'h6:       src_b = bus.D_rB;
      4'h8, 4'h9, 4'hA, 4'hB: src_b = 4'h4;
      default: ;
    endcase
    // cmov always names rB here; the condition is applied in execute
    case (bus.D_icode)
      4'h2, 4'h3, 4'h6:       dst_e = bus.D_rB;
      4'h8, 4'h9, 4'hA, 4'hB: dst_e = 4'h4;
      default: ;
    endcase
    case (bus.D_icode)
      4'h5, 4'hB: dst_m = bus.D_rA;
      default: ;
    endcase
  end

  // Youngest producer wins; a W-stage match also covers the same-cycle write.
  always_comb begin
    val_a = rf_q[src_a];
    if (bus.D_icode == 4'h7 || bus.D_icode == 4'h8) val_a = bus.D_valP;
    else if (src_a == RNONE)        val_a = 64'h0;
    else if (src_a == bus.e_dstE)   val_a = bus.e_valE;
    else if (src_a == bus.M_dstM)   val_a = bus.m_valM;
    else if (src_a == bus.M_dstE)   val_a = bus.M_valE;
    else if (src_a == bus.W_dstM)   val_a = bus.W_valM;
    else if (src_a == bus.W_dstE)   val_a = bus.W_valE;
  end

  always_comb begin
    val_b = rf_q[src_b];
    if (src_b == RNONE)             val_b = 64'h0;
    else if (src_b == bus.e_dstE)   val_b = bus.e_valE;
    else if (src_b == bus.M_dstM)   val_b = bus.m_valM;
    else if (src_b == bus.M_dstE)   val_b = bus.M_valE;
    else if (src_b == bus.W_dstM)   val_b = bus.W_valM;
    else if (src_b == bus.W_dstE)   val_b = bus.W_valE;
  end

  // dstM written last so popq %rsp keeps the loaded value
  always_comb begin
    rf_d = rf_q;
    if (bus.W_stat == STAT_AOK) begin
      if (bus.W_dstE != RNONE) rf_d[bus.W_dstE] = bus.W_valE;
      if (bus.W_dstM != RNONE) rf_d[bus.W_dstM] = bus.W_valM;
    end
  end

  always_comb begin
    e_d = E_NOP;
    if (!bus.E_bubble)
      e_d = '{icode: bus.D_icode, ifun: bus.D_ifun, dstE: dst_e, dstM: dst_m,
              srcA: src_a, srcB: src_b, valA: val_a, valB: val_b,
              valC: bus.D_valC, stat: bus.D_stat};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_q <= '0;
      e_q  <= E_NOP;
    end else begin
      rf_q <= rf_d;
      e_q  <= e_d;
    end
  end

  assign bus.d_srcA  = src_a;
  assign bus.d_srcB  = src_b;
  assign bus.E_icode = e_q.icode;
  assign bus.E_ifun  = e_q.ifun;
  assign bus.E_dstE  = e_q.dstE;
  assign bus.E_dstM  = e_q.dstM;
  assign bus.E_srcA  = e_q.srcA;
  assign bus.E_srcB  = e_q.srcB;
  assign bus.E_valA  = e_q.valA;
  assign bus.E_valB  = e_q.valB;
  assign bus.E_valC  = e_q.valC;
  assign bus.E_stat  = e_q.stat;
  assign bus.reg0    = rf_q[0];
  assign bus.reg1    = rf_q[1];
  assign bus.reg2    = rf_q[2];
  assign bus.reg3    = rf_q[3];
  assign bus.reg4    = rf_q[4];
  assign bus.reg5    = rf_q[5];
  assign bus.reg6    = rf_q[6];
  assign bus.reg7    = rf_q[7];
  assign bus.reg8    = rf_q[8];
  assign bus.reg9    = rf_q[9];
  assign bus.reg10   = rf_q[10];
  assign bus.reg11   = rf_q[11];
  assign bus.reg12   = rf_q[12];
  assign bus.reg13   = rf_q[13];
  assign bus.reg14   = rf_q[14];
  assign bus.reg15   = rf_q[15];
endmodule

// File: tb/tb_decode_regfile.sv
// Directed scenarios plus randomized traffic against an array-based model of
// the decode stage.
module tb_decode_regfile;
  localparam logic [1:0] AOK = 2'b00;
  localparam logic [3:0] RN  = 4'hF;

  logic clk = 1'b0;
  logic rst;
  int   n_pass = 0;
  int   n_total = 0;
  logic [63:0] m_rf [16];

  decode_regfile_if bus ();
  decode_regfile dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.D_icode = 4'h1; bus.D_ifun = 4'h0; bus.D_rA = RN; bus.D_rB = RN;
    bus.D_valC = '0; bus.D_valP = '0; bus.D_stat = AOK; bus.E_bubble = 1'b0;
    bus.e_dstE = RN; bus.e_valE = '0;
    bus.M_dstE = RN; bus.M_dstM = RN; bus.M_valE = '0; bus.m_valM = '0;
    bus.W_dstE = RN; bus.W_dstM = RN; bus.W_valE = '0; bus.W_valM = '0;
    bus.W_stat = AOK;
  endtask

  // ---- reference model ----
  function automatic logic [3:0] ref_srcA();
    if (bus.D_icode inside {4'h2, 4'h4, 4'h6, 4'hA}) return bus.D_rA;
    if (bus.D_icode inside {4'h9, 4'hB}) return 4'h4;
    return RN;
  endfunction
  function automatic logic [3:0] ref_srcB();
    if (bus.D_icode inside {4'h4, 4'h5, 4'h6}) return bus.D_rB;
    if (bus.D_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return RN;
  endfunction
  function automatic logic [3:0] ref_dstE();
    if (bus.D_icode inside {4'h2, 4'h3, 4'h6}) return bus.D_rB;
    if (bus.D_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return RN;
  endfunction
  function automatic logic [3:0] ref_dstM();
    return (bus.D_icode inside {4'h5, 4'hB}) ? bus.D_rA : RN;
  endfunction
  function automatic logic [63:0] ref_read(input logic [3:0] src);
    logic [3:0]  dsts [5];
    logic [63:0] vals [5];
    dsts = '{bus.e_dstE, bus.M_dstM, bus.M_dstE, bus.W_dstM, bus.W_dstE};
    vals = '{bus.e_valE, bus.m_valM, bus.M_valE, bus.W_valM, bus.W_valE};
    if (src == RN) return 64'h0;
    for (int k = 0; k < 5; k++) if (dsts[k] == src) return vals[k];
    return m_rf[src];
  endfunction
  function automatic logic [217:0] ref_e();
    logic [63:0] va;
    if (bus.E_bubble) return {4'h1, 4'h0, RN, RN, RN, RN, 64'h0, 64'h0, 64'h0, AOK};
    va = (bus.D_icode == 4'h7 || bus.D_icode == 4'h8) ? bus.D_valP : ref_read(ref_srcA());
    return {bus.D_icode, bus.D_ifun, ref_dstE(), ref_dstM(), ref_srcA(), ref_srcB(),
            va, ref_read(ref_srcB()), bus.D_valC, bus.D_stat};
  endfunction
  task automatic ref_write();
    if (bus.W_stat == AOK) begin
      if (bus.W_dstE != RN) m_rf[bus.W_dstE] = bus.W_valE;
      if (bus.W_dstM != RN) m_rf[bus.W_dstM] = bus.W_valM;
    end
  endtask
  function automatic logic [217:0] act_e();
    return {bus.E_icode, bus.E_ifun, bus.E_dstE, bus.E_dstM, bus.E_srcA, bus.E_srcB,
            bus.E_valA, bus.E_valB, bus.E_valC, bus.E_stat};
  endfunction
  function automatic logic [1023:0] act_regs();
    return {bus.reg15, bus.reg14, bus.reg13, bus.reg12, bus.reg11, bus.reg10, bus.reg9,
            bus.reg8, bus.reg7, bus.reg6, bus.reg5, bus.reg4, bus.reg3, bus.reg2,
            bus.reg1, bus.reg0};
  endfunction

  // ---- scenarios ----
  task automatic test_reset();
    set_idle();
    bus.W_dstE = 4'h3; bus.W_valE = 64'h5;
    rst = 1'b1;
    tick(); tick();
    set_idle();
    rst = 1'b0;
    n_total++; if (bus.reg3 !== 64'h0) $display("FAIL reset_reg3 got %h exp 0", bus.reg3); else n_pass++;
    n_total++; if (act_regs() !== '0) $display("FAIL reset_regs got %h exp 0", act_regs()); else n_pass++;
    n_total++; if (bus.E_icode !== 4'h1) $display("FAIL reset_E_icode got %h exp 1", bus.E_icode); else n_pass++;
    n_total++; if ({bus.E_dstE, bus.E_dstM, bus.E_srcA, bus.E_srcB} !== 16'hFFFF)
      $display("FAIL reset_E_ids got %h exp ffff", {bus.E_dstE, bus.E_dstM, bus.E_srcA, bus.E_srcB}); else n_pass++;
    n_total++; if ({bus.E_valA, bus.E_valB, bus.E_valC, bus.E_stat, bus.E_ifun} !== '0)
      $display("FAIL reset_E_vals got %h exp 0", {bus.E_valA, bus.E_valB, bus.E_valC}); else n_pass++;
  endtask

  task automatic test_writeback_read();
    set_idle();
    bus.W_dstE = 4'h2; bus.W_valE = 64'h1234;
    tick();
    set_idle();
    n_total++; if (bus.reg2 !== 64'h1234) $display("FAIL wb_reg2 got %h exp 1234", bus.reg2); else n_pass++;
    bus.D_icode = 4'h6; bus.D_rA = 4'h2; bus.D_rB = 4'h2;
    #1;
    n_total++; if ({bus.d_srcA, bus.d_srcB} !== 8'h22) $display("FAIL wb_dsrc got %h exp 22", {bus.d_srcA, bus.d_srcB}); else n_pass++;
    tick();
    n_total++; if (bus.E_valA !== 64'h1234 || bus.E_valB !== 64'h1234)
      $display("FAIL wb_E_vals got %h/%h exp 1234/1234", bus.E_valA, bus.E_valB); else n_pass++;
    n_total++; if (bus.E_dstE !== 4'h2) $display("FAIL wb_E_dstE got %h exp 2", bus.E_dstE); else n_pass++;
  endtask

  task automatic test_forward_priority();
    set_idle();
    bus.D_icode = 4'h2; bus.D_rA = 4'h3; bus.D_rB = 4'h0;
    bus.e_dstE = 4'h3; bus.e_valE = 64'hA;
    bus.M_dstM = 4'h3; bus.m_valM = 64'hB;
    bus.W_dstE = 4'h3; bus.W_valE = 64'hC;
    tick();
    n_total++; if (bus.E_valA !== 64'hA) $display("FAIL fwd_e got %h exp a", bus.E_valA); else n_pass++;
    bus.e_dstE = RN;
    tick();
    n_total++; if (bus.E_valA !== 64'hB) $display("FAIL fwd_m got %h exp b", bus.E_valA); else n_pass++;
    bus.M_dstM = RN; bus.W_dstE = RN; bus.W_dstM = 4'h3; bus.W_valM = 64'hD;
    tick();
    n_total++; if (bus.E_valA !== 64'hD) $display("FAIL fwd_w got %h exp d", bus.E_valA); else n_pass++;
  endtask

  task automatic test_popq();
    set_idle();
    bus.W_dstE = 4'h4; bus.W_valE = 64'h100;
    bus.W_dstM = 4'h4; bus.W_valM = 64'h55;
    tick();
    set_idle();
    n_total++; if (bus.reg4 !== 64'h55) $display("FAIL popq_reg4 got %h exp 55", bus.reg4); else n_pass++;
  endtask

  task automatic test_call();
    set_idle();
    bus.D_icode = 4'h8; bus.D_valP = 64'h40;
    tick();
    n_total++; if (bus.E_valA !== 64'h40) $display("FAIL call_valA got %h exp 40", bus.E_valA); else n_pass++;
    n_total++; if ({bus.E_srcA, bus.E_srcB, bus.E_dstE, bus.E_dstM} !== 16'hF44F)
      $display("FAIL call_ids got %h exp f44f", {bus.E_srcA, bus.E_srcB, bus.E_dstE, bus.E_dstM}); else n_pass++;
  endtask

  task automatic test_bubble();
    set_idle();
    bus.D_icode = 4'h6; bus.D_rA = 4'h1; bus.D_rB = 4'h2; bus.D_valC = 64'h99;
    bus.E_bubble = 1'b1;
    tick();
    n_total++; if (bus.E_icode !== 4'h1 || bus.E_dstE !== RN)
      $display("FAIL bubble got icode %h dstE %h exp 1/f", bus.E_icode, bus.E_dstE); else n_pass++;
    n_total++; if (bus.E_valC !== 64'h0) $display("FAIL bubble_valC got %h exp 0", bus.E_valC); else n_pass++;
  endtask

  task automatic test_stat_gate();
    set_idle();
    bus.W_dstE = 4'h1; bus.W_valE = 64'h77;
    tick();
    set_idle();
    bus.W_stat = 2'b01; bus.W_dstE = 4'h1; bus.W_valE = 64'h99;
    bus.W_dstM = 4'h7; bus.W_valM = 64'h88;
    bus.D_icode = 4'h6; bus.D_rA = 4'h5; bus.D_rB = 4'h5;
    tick();
    n_total++; if (bus.reg1 !== 64'h77 || bus.reg7 !== 64'h0)
      $display("FAIL stat_gate got reg1 %h reg7 %h exp 77/0", bus.reg1, bus.reg7); else n_pass++;
    n_total++; if (bus.E_icode !== 4'h6 || bus.E_dstE !== 4'h5)
      $display("FAIL stat_gate_E got %h/%h exp 6/5", bus.E_icode, bus.E_dstE); else n_pass++;
  endtask

  task automatic test_reset_mid();
    set_idle();
    bus.W_dstE = 4'h6; bus.W_valE = 64'h123;
    bus.D_icode = 4'h6; bus.D_rA = 4'h1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_idle();
    n_total++; if (bus.reg6 !== 64'h0 || bus.reg1 !== 64'h0)
      $display("FAIL rst_mid_regs got %h/%h exp 0/0", bus.reg6, bus.reg1); else n_pass++;
    n_total++; if (bus.E_icode !== 4'h1) $display("FAIL rst_mid_E got %h exp 1", bus.E_icode); else n_pass++;
  endtask

  function automatic logic [3:0] rid();
    return ($urandom_range(0, 4) == 0) ? RN : 4'($urandom_range(0, 7));
  endfunction

  task automatic test_random();
    logic [217:0]  exp_e;
    logic [1023:0] exp_r;
    logic [7:0]    exp_s;
    set_idle();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    for (int it = 0; it < 400; it++) begin
      bus.D_icode = 4'($urandom_range(0, 11)); bus.D_ifun = 4'($urandom_range(0, 6));
      bus.D_rA = rid(); bus.D_rB = rid();
      bus.D_valC = {$urandom, $urandom}; bus.D_valP = {$urandom, $urandom};
      bus.D_stat = 2'($urandom_range(0, 3));
      bus.E_bubble = ($urandom_range(0, 7) == 0);
      bus.e_dstE = rid(); bus.e_valE = {$urandom, $urandom};
      bus.M_dstE = rid(); bus.M_valE = {$urandom, $urandom};
      bus.M_dstM = rid(); bus.m_valM = {$urandom, $urandom};
      bus.W_dstE = rid(); bus.W_valE = {$urandom, $urandom};
      bus.W_dstM = rid(); bus.W_valM = {$urandom, $urandom};
      bus.W_stat = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : AOK;
      #1;
      exp_s = {ref_srcA(), ref_srcB()};
      n_total++; if ({bus.d_srcA, bus.d_srcB} !== exp_s)
        $display("FAIL rnd_dsrc it %0d got %h exp %h", it, {bus.d_srcA, bus.d_srcB}, exp_s); else n_pass++;
      exp_e = ref_e();
      ref_write();
      for (int i = 0; i < 16; i++) exp_r[i*64 +: 64] = m_rf[i];
      tick();
      n_total++; if (act_e() !== exp_e)
        $display("FAIL rnd_E it %0d got %h exp %h", it, act_e(), exp_e); else n_pass++;
      n_total++; if (act_regs() !== exp_r)
        $display("FAIL rnd_regs it %0d got %h exp %h", it, act_regs(), exp_r); else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b0;
    set_idle();
    test_reset();
    test_writeback_read();
    test_forward_priority();
    test_popq();
    test_call();
    test_bubble();
    test_stat_gate();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
